shiftreg_univ_seq: RTL

SHIFTREG_UNIV_SEQ -- requirements
Module: shiftreg_univ_seq

---
 rtl/shiftreg_pkg.sv | 16 +
 rtl/shift1_unit.sv | 43 ++++
 rtl/shiftreg_univ_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// Shared constants for the universal sequential shift register:
// FSM state encoding and shift-mode encoding.
package shiftreg_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Shift-mode encoding
    localparam logic [1:0] MODE_SLL = 2'b00;  // shift left, fill with serial bit
    localparam logic [1:0] MODE_SRL = 2'b01;  // logical right, fill with serial bit
    localparam logic [1:0] MODE_SRA = 2'b10;  // arithmetic right, replicate MSB
    localparam logic [1:0] MODE_ROL = 2'b11;  // rotate left

endpackage

// File: rtl/shift1_unit.sv
// Combinational single-step shifter: applies one 1-bit operation of the
// selected mode and reports the bit that falls off the register.
module shift1_unit
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       mode_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] data_o,
    output logic             sout_o
);

    // One-position shift of data_i according to mode_i
    always_comb begin
        data_o = data_i;
        sout_o = 1'b0;
        case (mode_i)
            MODE_SLL: begin
                data_o = {data_i[WIDTH-2:0], sin_i};
                sout_o = data_i[WIDTH-1];
            end
            MODE_SRL: begin
                data_o = {sin_i, data_i[WIDTH-1:1]};
                sout_o = data_i[0];
            end
            MODE_SRA: begin
                data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
                sout_o = data_i[0];
            end
            MODE_ROL: begin
                data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
                sout_o = data_i[WIDTH-1];
            end
            default: begin
                data_o = data_i;
                sout_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shiftreg_univ_seq.sv
// Universal shift register with parallel load and a multi-cycle shift
// sequencer (IDLE -> SHIFT -> DONE). One bit moves per clock while shifting.
module shiftreg_univ_seq
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT  = CNT_W'(0);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             sout_q,  sout_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       mode_q,  mode_d;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] k_s;
    logic [WIDTH-1:0] shift_data_s;
    logic             shift_sout_s;

    // Shift count requested by the user, clamped so a full-width request
    // never runs longer than WIDTH cycles.
    always_comb begin
        if (amount > WIDTH_CNT) begin
            k_s = WIDTH_CNT;
        end else begin
            k_s = amount;
        end
    end

    shift1_unit #(
        .WIDTH (WIDTH)
    ) u_shift1 (
        .data_i (data_q),
        .mode_i (mode_q),
        .sin_i  (sin),
        .data_o (shift_data_s),
        .sout_o (shift_sout_s)
    );

    // Next-state logic for the sequencer and the datapath registers
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    // load wins over a simultaneous start
                    data_d = in;
                end else if (start) begin
                    mode_d = mode;
                    cnt_d  = k_s;
                    if (k_s != ZERO_CNT) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d = shift_data_s;
                sout_d = shift_sout_s;
                cnt_d  = cnt_q - ONE_CNT;
                if (cnt_q <= ONE_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are registered decodes of the
    // next state so they line up exactly with SHIFT and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= {WIDTH{1'b0}};
            sout_q  <= 1'b0;
            cnt_q   <= ZERO_CNT;
            mode_q  <= MODE_SLL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= (state_d == ST_SHIFT);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign out  = data_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
